// File: rtl/fft_buf_pkg.sv
// Shared definitions for the stride permutation buffer.
//   wr_state_e / rd_state_e : write-side and read-side FSM state encodings
//   rotl()   : rotate a log_n-bit address left by sh bits
//   bitrev() : reverse the low log_n bits of an address
// Addresses are carried in MaxLogN-bit containers. Bits at or above log_n are
// ignored on input and returned as zero.
package fft_buf_pkg;

  localparam int unsigned MaxLogN = 16;

  typedef enum logic [0:0] {
    WrWaitStart = 1'b0,
    WrFill      = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    RdIdle  = 1'b0,
    RdDrain = 1'b1
  } rd_state_e;

  // Caller must keep sh <= log_n and log_n <= MaxLogN.
  function automatic logic [MaxLogN-1:0] rotl(input logic [MaxLogN-1:0] a,
                                               input int unsigned log_n,
                                               input int unsigned sh);
    logic [MaxLogN-1:0] mask;
    logic [MaxLogN-1:0] am;
    mask = ~({MaxLogN{1'b1}} << log_n);
    am   = a & mask;
    return ((am << sh) | (am >> (log_n - sh))) & mask;
  endfunction

  function automatic logic [MaxLogN-1:0] bitrev(input logic [MaxLogN-1:0] a,
                                                input int unsigned log_n);
    logic [MaxLogN-1:0] mask;
    logic [MaxLogN-1:0] am;
    logic [MaxLogN-1:0] rev;
    mask = ~({MaxLogN{1'b1}} << log_n);
    am   = a & mask;
    rev  = {<<{am}};
    // The full-width reverse puts the low log_n bits at the top; shift them back down.
    return rev >> (MaxLogN - log_n);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one registered synchronous read port.
//   clk, rst      : clock and async active-high reset (clears only the read register)
//   we/waddr/wdata: write port
//   re/raddr      : read enable and address; rdata updates on the next edge when re=1
//   rdata         : registered read data; it holds its value while re=0
module sdp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = re ? mem[raddr] : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/stride_perm_buffer.sv
// Ping-pong block buffer that applies the stride permutation L(N,S):
// y[k] = x[rotl(k, LOG_S)], with N = 2**LOG_N. One bank fills in natural
// order while the other drains in permuted order. Output latency is 2 cycles
// after the last sample of a block is accepted.
//   clk, rst            : clock and async active-high reset
//   data_in/in_valid    : input samples; gaps are allowed
//   in_start            : marks sample 0 of a block (qualified by in_valid)
//   data_out            : permuted sample, registered; it holds when out_valid=0
//   out_valid/out_start : output qualifier and block-start marker
// Optional feature (macro PERM_BITREV_EN): adds the mode_bitrev input. It is
// sampled with in_start, and a block with mode_bitrev=1 is output in
// bit-reversed order instead of the stride order.
module stride_perm_buffer
  import fft_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG_N      = 4,
  parameter int unsigned LOG_S      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  input  logic                  in_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  out_start
`ifdef PERM_BITREV_EN
  ,
  input  logic                  mode_bitrev
`endif
);

  localparam int unsigned AddrW = LOG_N + 1;
  localparam logic [LOG_N-1:0] LastIdx = '1;

  wr_state_e        wr_state_q, wr_state_d;
  logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             wr_en;
  logic [LOG_N-1:0] wr_idx;
  logic             blk_done;

  rd_state_e        rd_state_q, rd_state_d;
  logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_en;
  logic [LOG_N-1:0] rd_idx;

  logic             out_valid_q, out_valid_d;
  logic             out_start_q, out_start_d;

`ifdef PERM_BITREV_EN
  logic             wr_mode_q, wr_mode_d;
  logic             rd_mode_q, rd_mode_d;
`endif

  // Write side. A start in FILL restarts the block at index 0, which drops the partial block.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    blk_done   = 1'b0;
    wr_en      = in_valid && (in_start || (wr_state_q == WrFill));
    wr_idx     = in_start ? '0 : wr_cnt_q;
    if (wr_en) begin
      wr_state_d = WrFill;
      if (wr_idx == LastIdx) begin
        blk_done  = 1'b1;
        wr_bank_d = ~wr_bank_q;
        wr_cnt_d  = '0;
      end else begin
        wr_cnt_d = wr_idx + LOG_N'(1);
      end
    end
`ifdef PERM_BITREV_EN
    wr_mode_d = (wr_en && in_start) ? mode_bitrev : wr_mode_q;
`endif
  end

  // Read side. A completion on the last drain cycle chains straight into the next drain.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    rd_en      = (rd_state_q == RdDrain);
`ifdef PERM_BITREV_EN
    rd_mode_d  = rd_mode_q;
`endif
    if (blk_done) begin
      rd_state_d = RdDrain;
      rd_cnt_d   = '0;
      rd_bank_d  = wr_bank_q;
`ifdef PERM_BITREV_EN
      rd_mode_d  = wr_mode_d;
`endif
    end else if (rd_en) begin
      if (rd_cnt_q == LastIdx) rd_state_d = RdIdle;
      else                     rd_cnt_d   = rd_cnt_q + LOG_N'(1);
    end
    out_valid_d = rd_en;
    out_start_d = rd_en && (rd_cnt_q == '0);
  end

  always_comb begin
    rd_idx = LOG_N'(rotl(MaxLogN'(rd_cnt_q), LOG_N, LOG_S));
`ifdef PERM_BITREV_EN
    if (rd_mode_q) rd_idx = LOG_N'(bitrev(MaxLogN'(rd_cnt_q), LOG_N));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WrWaitStart;
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_state_q  <= RdIdle;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
`ifdef PERM_BITREV_EN
      wr_mode_q   <= 1'b0;
      rd_mode_q   <= 1'b0;
`endif
    end else begin
      wr_state_q  <= wr_state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_state_q  <= rd_state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
`ifdef PERM_BITREV_EN
      wr_mode_q   <= wr_mode_d;
      rd_mode_q   <= rd_mode_d;
`endif
    end
  end

  // The RAM read register doubles as the data_out register.
  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AddrW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr({wr_bank_q, wr_idx}),
    .wdata(data_in),
    .re   (rd_en),
    .raddr({rd_bank_q, rd_idx}),
    .rdata(data_out)
  );

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;

endmodule

// File: tb/tb_stride_perm_buffer.sv
// Directed bench for stride_perm_buffer (N=16, S=4) plus a LOG_S=0 instance
// that must produce identity order. It checks the mode_bitrev path when
// PERM_BITREV_EN is defined.
module tb_stride_perm_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_start = 1'b0;
  logic        mode_bitrev = 1'b0;
  logic [31:0] data_out, data_out_id;
  logic        out_valid, out_valid_id;
  logic        out_start, out_start_id;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  int q_data[$];
  int q_start[$];
  int q_cyc[$];
  int q_id[$];

  int stride_tbl[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int bitrev_tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  stride_perm_buffer #(.DATA_WIDTH(32), .LOG_N(4), .LOG_S(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_start (in_start),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_start(out_start)
`ifdef PERM_BITREV_EN
    ,
    .mode_bitrev(mode_bitrev)
`endif
  );

  stride_perm_buffer #(.DATA_WIDTH(32), .LOG_N(4), .LOG_S(0)) u_dut_id (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_start (in_start),
    .data_out (data_out_id),
    .out_valid(out_valid_id),
    .out_start(out_start_id)
`ifdef PERM_BITREV_EN
    ,
    .mode_bitrev(mode_bitrev)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_data.push_back(int'(data_out));
      q_start.push_back(int'(out_start));
      q_cyc.push_back(cyc);
    end
    if (out_valid_id) q_id.push_back(int'(data_out_id));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    in_start = s;
    data_in  = d;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_q();
    q_data.delete();
    q_start.delete();
    q_cyc.delete();
    q_id.delete();
  endtask

  // Contiguous 16-sample block with values base..base+15.
  task automatic send_block(input int base, output int c_first, output int c_last);
    c_first = 0;
    c_last  = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)  c_first = cyc;
      if (i == 15) c_last = cyc;
      drive(1'b1, (i == 0), 32'(base + i));
    end
  endtask

  task automatic check_block(input string tag, input int base, input int first_cyc,
                             input int qoff, input bit br);
    int ex;
    if (q_data.size() < qoff + 16) begin
      chk({tag, ".count"}, 32'(q_data.size()), 32'(qoff + 16));
    end else begin
      for (int i = 0; i < 16; i++) begin
        ex = base + (br ? bitrev_tbl[i] : stride_tbl[i]);
        chk($sformatf("%s.data[%0d]", tag, i), 32'(q_data[qoff + i]), 32'(ex));
        chk($sformatf("%s.start[%0d]", tag, i), 32'(q_start[qoff + i]), 32'(i == 0));
        chk($sformatf("%s.cyc[%0d]", tag, i), 32'(q_cyc[qoff + i]), 32'(first_cyc + i));
      end
    end
  endtask

  initial begin
    int cf, cl, cf0, cl1, cl2;

    // Reset state while rst is held.
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_start", 32'(out_start), 32'd0);
    chk("rst.data_out", data_out, 32'd0);
    rst = 1'b0;
    while (cyc < 10) tick();

    // A: single block, in_start at cycle 10 -> out_start at cycle 27.
    clear_q();
    send_block(0, cf, cl);
    chk("A.first_in_cyc", 32'(cf), 32'd10);
    idle(20);
    chk("A.count", 32'(q_data.size()), 32'd16);
    check_block("A", 0, 27, 0, 1'b0);
    chk("A.id.count", 32'(q_id.size()), 32'd16);
    for (int i = 0; i < 16 && i < q_id.size(); i++)
      chk($sformatf("A.id[%0d]", i), 32'(q_id[i]), 32'(i));
    chk("A.hold.data_out", data_out, 32'd15);
    chk("A.hold.out_valid", 32'(out_valid), 32'd0);

    // B: three back-to-back blocks, values 0..47.
    clear_q();
    send_block(0, cf0, cl);
    send_block(16, cf, cl);
    send_block(32, cf, cl);
    idle(25);
    chk("B.count", 32'(q_data.size()), 32'd48);
    check_block("B0", 0, cf0 + 17, 0, 1'b0);
    check_block("B1", 16, cf0 + 33, 16, 1'b0);
    check_block("B2", 32, cf0 + 49, 32, 1'b0);

    // C: in_valid low every other cycle.
    clear_q();
    cl = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cl = cyc;
      drive(1'b1, (i == 0), 32'(100 + i));
      drive(1'b0, 1'b0, 32'hdead);
    end
    idle(25);
    chk("C.count", 32'(q_data.size()), 32'd16);
    check_block("C", 100, cl + 2, 0, 1'b0);

    // D: restart at count 7 drops the partial block.
    clear_q();
    for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), 32'(200 + i));
    send_block(300, cf, cl);
    idle(25);
    chk("D.count", 32'(q_data.size()), 32'd16);
    check_block("D", 300, cl + 2, 0, 1'b0);

    // E: reset in the middle of a drain, then samples without in_start are discarded.
    clear_q();
    send_block(400, cf, cl1);
    idle(0);
    while (cyc < cl1 + 5) tick();
    rst = 1'b1;
    tick();
    chk("E.rst.out_valid", 32'(out_valid), 32'd0);
    chk("E.rst.out_start", 32'(out_start), 32'd0);
    chk("E.rst.data_out", data_out, 32'd0);
    rst = 1'b0;
    chk("E.partial.count", 32'(q_data.size()), 32'd3);
    for (int i = 0; i < 3 && i < q_data.size(); i++)
      chk($sformatf("E.partial[%0d]", i), 32'(q_data[i]), 32'(400 + stride_tbl[i]));
    idle(25);
    chk("E.quiet.count", 32'(q_data.size()), 32'd3);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'(450 + i));
    idle(3);
    send_block(500, cf, cl2);
    idle(25);
    chk("E.count", 32'(q_data.size()), 32'd19);
    check_block("E", 500, cl2 + 2, 3, 1'b0);

`ifdef PERM_BITREV_EN
    // F: bit-reversed block followed by a stride block; mode is latched per block.
    clear_q();
    mode_bitrev = 1'b1;
    send_block(600, cf0, cl);
    mode_bitrev = 1'b0;
    send_block(700, cf, cl);
    idle(25);
    chk("F.count", 32'(q_data.size()), 32'd32);
    check_block("F0", 600, cf0 + 17, 0, 1'b1);
    check_block("F1", 700, cf0 + 33, 16, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
